serial_adder_ctrl: RTL and testbench

Sequencing controller for the team's 1-bit adder cell, used as a bit-serial adder/subtractor. It accepts two WIDTH-bit operands on a start handshake and feeds them LSB-first through a single full-adder cell, one bit per clock, with a registered carry. It presents the WIDTH-bit result and carry-out with a one-cycle done pulse. It sits between a simple requester (testbench or top-level sequencer) and the shared adder cell, and owns all timing of that cell.

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 29 ++
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding, default width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cntWidth(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial
// adder controller (slave).
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, a_in, b_in,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a_in, b_in,
        output ready, busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational, shared by the
// serial controller which owns all of its timing.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller: captures two operands, feeds them
// LSB-first through one full_adder with a registered carry, then pulses done.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int              CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   aReg_q, aReg_d;
    logic [WIDTH-1:0]   bReg_q, bReg_d;
    logic [WIDTH-2:0]   resReg_q, resReg_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               faSum;
    logic               faCout;
    logic [WIDTH-1:0]   resNext;

    full_adder u_fullAdder (
        .a    (aReg_q[0]),
        .b    (bReg_q[0]),
        .cin  (carry_q),
        .s    (faSum),
        .cout (faCout)
    );

    // The partial result keeps WIDTH-1 bits; the last sum bit lands directly
    // in the output register on the final SHIFT edge.
    assign resNext = {faSum, resReg_q};

    // Subtraction mode lives entirely in the inverted B operand and the
    // initial carry of 1, so nothing downstream needs to remember it.
    always_comb begin
        state_d  = state_q;
        aReg_d   = aReg_q;
        bReg_d   = bReg_q;
        resReg_d = resReg_q;
        carry_d  = carry_q;
        count_d  = count_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    aReg_d  = bus.a_in;
                    bReg_d  = bus.sub ? ~bus.b_in : bus.b_in;
                    carry_d = bus.sub;
                    count_d = '0;
                end
            end
            SHIFT: begin
                aReg_d   = aReg_q >> 1;
                bReg_d   = bReg_q >> 1;
                resReg_d = resNext[WIDTH-1:1];
                carry_d  = faCout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                    sum_d   = resNext;
                    cout_d  = faCout;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aReg_q   <= '0;
            bReg_q   <= '0;
            resReg_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aReg_q   <= aReg_d;
            bReg_q   <= bReg_d;
            resReg_q <= resReg_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8 with
// hand-computed sums, carries and handshake timing.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Global guard so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // One complete operation: start pulse, scramble the operands after the
    // accepting edge, then check latency, result and return to IDLE.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                 input logic [7:0] expSum, input logic expCout,
                                 input string tag);
        int cycles;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(bus.ready), 32'd1);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        bus.sub   = ~sub;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(expCout));
        @(posedge clk);
        #1;
        checkOutput({tag, "_doneLow"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_readyBack"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int doneCount;
        int doneAt;
        int readyAt;
        int cycles;
        logic [7:0] gotSum;
        logic [7:0] b2bA    [5] = '{8'h12, 8'hF0, 8'h33, 8'h80, 8'hC3};
        logic [7:0] b2bB    [5] = '{8'h34, 8'h20, 8'h44, 8'h7F, 8'h3C};
        logic       b2bSub  [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        logic [7:0] b2bSum  [4] = '{8'h46, 8'h10, 8'hEF, 8'h01};
        logic       b2bCout [4] = '{1'b0,  1'b1,  1'b0,  1'b1};

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;

        #12;
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_busy",  32'(bus.busy),  32'd0);
        checkOutput("rst_done",  32'(bus.done),  32'd0);
        checkOutput("rst_sum",   32'(bus.sum),   32'd0);
        checkOutput("rst_cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "add3C05");
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addFF01");
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "add8080");
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add0000");
        applyStimulus(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub1001");
        applyStimulus(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "sub0001");
        applyStimulus(8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, "sub5A5A");

        // A second start during SHIFT must be ignored entirely.
        @(negedge clk);
        bus.a_in  = 8'h01;
        bus.b_in  = 8'h01;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busyProt_busy", 32'(bus.busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        bus.a_in  = 8'hAA;
        bus.b_in  = 8'h55;
        bus.start = 1'b1;
        checkOutput("busyProt_sumHold",  32'(bus.sum),   32'h00);
        checkOutput("busyProt_coutHold", 32'(bus.cout),  32'd1);
        checkOutput("busyProt_readyLow", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        doneCount = 0;
        doneAt    = -1;
        readyAt   = -1;
        gotSum    = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done === 1'b1) begin
                doneCount++;
                doneAt = i;
                gotSum = bus.sum;
            end
            if (bus.ready === 1'b1 && readyAt < 0) readyAt = i;
            @(posedge clk);
            #1;
        end
        checkOutput("busyProt_doneCount", 32'(doneCount), 32'd1);
        checkOutput("busyProt_sum", 32'(gotSum), 32'h02);
        checkOutput("busyProt_readyAfterDone", 32'(readyAt), 32'(doneAt + 1));

        // Asynchronous reset in SHIFT cycle 4 of 0xFF+0xFF.
        @(negedge clk);
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_ready", 32'(bus.ready), 32'd1);
        checkOutput("midRst_busy",  32'(bus.busy),  32'd0);
        checkOutput("midRst_done",  32'(bus.done),  32'd0);
        checkOutput("midRst_sum",   32'(bus.sum),   32'd0);
        checkOutput("midRst_cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("midRst_noDone", 32'(doneCount), 32'd0);
        applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "postRst");

        // Start held high: DONE returns to IDLE unconditionally, so each
        // new operation is taken on the edge that ends the single IDLE cycle.
        @(negedge clk);
        bus.a_in  = b2bA[0];
        bus.b_in  = b2bB[0];
        bus.sub   = b2bSub[0];
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b%0d_accepted", i), 32'(bus.busy), 32'd1);
            bus.a_in = b2bA[i + 1];
            bus.b_in = b2bB[i + 1];
            bus.sub  = b2bSub[i + 1];
            waitDone(cycles);
            checkOutput($sformatf("b2b%0d_latency", i), 32'(cycles), 32'(WIDTH));
            checkOutput($sformatf("b2b%0d_sum", i), 32'(bus.sum), 32'(b2bSum[i]));
            checkOutput($sformatf("b2b%0d_cout", i), 32'(bus.cout), 32'(b2bCout[i]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b%0d_ready", i), 32'(bus.ready), 32'd1);
            if (i == 3) bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("b2b_stopped", 32'(bus.ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
